uart_line_buffer: RTL and testbench
===================================

Name: uart_line_buffer

Overview:
- Parametrised receive/echo buffer that sits between the existing uart_rx and uart_tx instances, clocked by the 12 MHz hwclk.
- Collects received bytes into a DEPTH-entry buffer.
- Echoes the buffer back when it fills or when a configurable terminator byte arrives.
- Echo order is selectable: reversed (LIFO) or in arrival order (FIFO).

Parameters:
- DEPTH, 4, buffer entries (2..256); LW = $clog2(DEPTH+1).
- MODE, 0, drain order: 0 = LIFO (last received first), 1 = FIFO (arrival order).
- FLUSH_EN, 1, 1 = terminator byte triggers drain before buffer is full.
- FLUSH_CHAR, 8'h0D, terminator byte value (used only when FLUSH_EN = 1).

Ports:
- hwclk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert is done outside this block.
- rx_dv  input  1  one-cycle strobe from uart_rx: rx_byte is valid.
- rx_byte  input  8  received byte.
- tx_active  input  1  uart_tx busy.
- tx_done  input  1  one-cycle strobe from uart_tx: byte fully sent.
- tx_dv  output  1  one-cycle start strobe to uart_tx.
- tx_byte  output  8  byte to transmit; held stable from tx_dv until tx_done.
- busy  output  1  high while draining (FSM not in FILL).
- drop  output  1  one-cycle pulse: an rx byte was discarded.
- level  output  LW  current number of stored bytes.

Behaviour:
- Reset (async, rst_n = 0):
  - State = FILL.
  - tx_dv = 0, tx_byte = 8'h00, busy = 0, drop = 0, level = 0.
  - All pointers = 0. Buffer contents are don't-care.
  - Reset mid-drain aborts immediately; any tx_dv in flight is cleared.
- FSM states: FILL, ISSUE, WAIT_DONE.
- FILL:
  - On rx_dv, write rx_byte at index level, then level <= level+1.
  - Go to ISSUE when the new level == DEPTH, or when FLUSH_EN and rx_byte == FLUSH_CHAR.
  - The terminator is stored and echoed like any other byte.
  - On entering ISSUE, load rd_idx: LIFO = new level-1, FIFO = 0.
- ISSUE:
  - Wait while tx_active = 1.
  - When tx_active = 0: tx_byte <= buf[rd_idx], assert tx_dv for exactly one cycle, go to WAIT_DONE.
- WAIT_DONE:
  - On tx_done: level <= level-1.
  - rd_idx steps toward the next entry: LIFO decrements, FIFO increments.
  - If the new level == 0, go to FILL (write index restarts at 0); otherwise go to ISSUE.
- Latency:
  - tx_dv is registered.
  - The first tx_dv is high in the cycle after the first edge where the FSM is in ISSUE and tx_active = 0.
  - With uart_tx idle, that is 2 hwclk cycles after the triggering rx_dv sample.
  - Between bytes: tx_done to next tx_dv = 2 cycles.
- Drop rule:
  - rx_dv in any state other than FILL discards the byte.
  - drop pulses in the following cycle.
  - level and buffer are unchanged.
- Simultaneous rx_dv and tx_done on the final byte: the FSM is still in WAIT_DONE that cycle, so the rx byte is dropped (drop = 1).
- Width rules:
  - level saturates by construction and never exceeds DEPTH.
  - rd_idx is $clog2(DEPTH) bits wide; no wrap-around is reachable.
- tx_done while in FILL or ISSUE: ignored (spurious), no state change.
- busy = (state != FILL), registered with the state.

Decomposition:
- Shared package uart_pkg:
  - State enum (ST_FILL, ST_ISSUE, ST_WAIT_DONE).
  - MODE_LIFO / MODE_FIFO constants.
  - Default FLUSH_CHAR constant.
- One sub-module: uart_buf_mem.
  - DEPTH x 8 storage.
  - Synchronous write, registered read, no reset on the array, so it infers iCE40 RAM/LUTs.
- The FSM, pointers and level counter stay in uart_line_buffer.

Test Plan:
- DEPTH=4, MODE=0, uart_tx model idle:
  - Stimulus: rx 'A','B','C','D'.
  - Required: tx_dv x4 with tx_byte 'D','C','B','A'; level reaches 4 and returns to 0; busy high only during drain.
- DEPTH=4, MODE=1:
  - Stimulus: rx 8'h01,8'h02,8'h03,8'h04.
  - Required: tx order 01,02,03,04; first tx_dv 2 cycles after the 4th rx_dv.
- FLUSH_EN=1, DEPTH=8, MODE=0:
  - Stimulus: rx 'h','i',8'h0D.
  - Required: drain after 3 bytes, tx 0D,'i','h'; then FILL with level=0.
- Drop:
  - Stimulus: during drain of case 1, inject rx 'Z' with the state in WAIT_DONE.
  - Required: drop pulses 1 cycle later; echo stream is unaffected; level is not incremented.
- Backpressure:
  - Stimulus: hold tx_active=1 for 50 cycles after the fill completes.
  - Required: no tx_dv until tx_active drops; then a single 1-cycle tx_dv.
- Reset mid-drain:
  - Stimulus: pull rst_n low after the 2nd tx_done of case 1.
  - Required: tx_dv, busy and level go to 0 immediately; after release, a fresh rx 'Q' fills to level=1 with no tx activity.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/echo line buffer: FSM states,
// drain-order selectors and the default terminator byte.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_ISSUE,
    ST_WAIT_DONE
  } state_t;

  localparam int MODE_LIFO = 0;
  localparam int MODE_FIFO = 1;

  localparam logic [7:0] DEFAULT_FLUSH_CHAR = 8'h0D;

endpackage

// File: rtl/uart_buf_mem.sv
// DEPTH x 8 byte store with synchronous write and registered read.
// The array has no reset so it can map onto block RAM or LUT RAM.
module uart_buf_mem #(
  parameter int  DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          hwclk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // A same-cycle write to the address being read is forwarded, because in
  // LIFO mode the last byte written is also the first byte echoed.
  always_ff @(posedge hwclk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/uart_line_buffer.sv
// Receive/echo line buffer between uart_rx and uart_tx: collects bytes and
// echoes them (LIFO or FIFO) when the buffer fills or a terminator arrives.
module uart_line_buffer
  import uart_pkg::*;
#(
  parameter int         DEPTH      = 4,
  parameter int         MODE       = MODE_LIFO,
  parameter int         FLUSH_EN   = 1,
  parameter logic [7:0] FLUSH_CHAR = DEFAULT_FLUSH_CHAR,
  localparam int        LW         = $clog2(DEPTH + 1)
) (
  input  logic          hwclk,
  input  logic          rst_n,
  input  logic          rx_dv,
  input  logic [7:0]    rx_byte,
  input  logic          tx_active,
  input  logic          tx_done,
  output logic          tx_dv,
  output logic [7:0]    tx_byte,
  output logic          busy,
  output logic          drop,
  output logic [LW-1:0] level
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        state, state_d;
  logic [LW-1:0] level_d;
  logic [IW-1:0] rd_idx, rd_idx_d;
  logic          tx_dv_d;
  logic [7:0]    tx_byte_d;
  logic          busy_d;
  logic          drop_d;
  logic          mem_we;
  logic [7:0]    mem_rd_data;

  // The read address follows the next-state read index so the registered
  // memory output already holds buf[rd_idx] whenever the FSM sits in ISSUE.
  uart_buf_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .hwclk   (hwclk),
    .we      (mem_we),
    .wr_addr (level[IW-1:0]),
    .wr_data (rx_byte),
    .rd_addr (rd_idx_d),
    .rd_data (mem_rd_data)
  );

  always_comb begin
    state_d   = state;
    level_d   = level;
    rd_idx_d  = rd_idx;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte;
    mem_we    = 1'b0;

    unique case (state)
      ST_FILL: begin
        if (rx_dv) begin
          mem_we  = 1'b1;
          level_d = level + LW'(1);
          if ((level_d == LW'(DEPTH)) ||
              ((FLUSH_EN != 0) && (rx_byte == FLUSH_CHAR))) begin
            state_d  = ST_ISSUE;
            rd_idx_d = (MODE == MODE_FIFO) ? '0 : level[IW-1:0];
          end
        end
      end

      ST_ISSUE: begin
        if (!tx_active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = mem_rd_data;
          state_d   = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (tx_done) begin
          level_d = level - LW'(1);
          if (level_d == '0) begin
            state_d = ST_FILL;
          end else begin
            state_d  = ST_ISSUE;
            rd_idx_d = (MODE == MODE_FIFO) ? (rd_idx + IW'(1)) : (rd_idx - IW'(1));
          end
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase

    drop_d = rx_dv && (state != ST_FILL);
    busy_d = (state_d != ST_FILL);
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_FILL;
      level   <= '0;
      rd_idx  <= '0;
      tx_dv   <= 1'b0;
      tx_byte <= 8'h00;
      busy    <= 1'b0;
      drop    <= 1'b0;
    end else begin
      state   <= state_d;
      level   <= level_d;
      rd_idx  <= rd_idx_d;
      tx_dv   <= tx_dv_d;
      tx_byte <= tx_byte_d;
      busy    <= busy_d;
      drop    <= drop_d;
    end
  end

endmodule

// File: tb/tb_uart_line_buffer.sv
// Self-checking bench: three buffer configurations, each with its own uart_tx
// model and a queue-based reference model, driven by vectors and random bytes.
module tb_uart_line_buffer;
  import uart_pkg::*;

  localparam int NI = 3;

  typedef struct {
    int          inst;
    int          n;
    logic [63:0] rx;
    logic [63:0] ex;
  } vec_t;

  logic             hwclk;
  logic             rst_n;
  logic [NI-1:0]    rx_dv;
  logic [7:0]       rx_byte [NI];
  logic [NI-1:0]    hold_active;
  logic [NI-1:0]    spur_done;
  logic [NI-1:0]    tx_dv_o, busy_o, drop_o, tx_done_o, model_busy;
  logic [7:0]       tx_byte_o [NI];
  logic [7:0]       level_o [NI];
  logic [7:0]       echo_q [NI][$];
  int               done_cnt [NI];
  int               errors;
  int               checks;
  vec_t             vecs [6];

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  task automatic check_output(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input int inst, input logic [7:0] b);
    @(negedge hwclk);
    rx_dv[inst]   = 1'b1;
    rx_byte[inst] = b;
    @(negedge hwclk);
    rx_dv[inst]   = 1'b0;
  endtask

  task automatic wait_idle(input int inst);
    int n;
    n = 0;
    while ((busy_o[inst] || model_busy[inst]) && (n < 2000)) begin
      @(negedge hwclk);
      n++;
    end
    check_output("drain_done", inst, {30'd0, busy_o[inst], model_busy[inst]}, 32'd0);
  endtask

  function automatic logic [7:0] get_byte(input logic [63:0] w, input int k);
    return w[63-8*k -: 8];
  endfunction

  task automatic check_echo(input string name, input int inst, input logic [63:0] ex, input int n);
    check_output({name, "_len"}, inst, echo_q[inst].size(), n);
    for (int k = 0; k < n; k++) begin
      check_output({name, "_byte"}, k,
                   (k < echo_q[inst].size()) ? {24'd0, echo_q[inst][k]} : 32'hFFFF_FFFF,
                   {24'd0, get_byte(ex, k)});
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D   = (g == 2) ? 8 : 4;
    localparam int M   = (g == 1) ? MODE_FIFO : MODE_LIFO;
    localparam int LWG = $clog2(D + 1);

    logic           tx_active, tx_done_m, tx_done_in;
    logic           tx_dv, busy, drop;
    logic [7:0]     tx_byte;
    logic [LWG-1:0] level;
    int             tx_cnt;

    logic [7:0]     store [$];
    logic [7:0]     pend [$];
    bit             draining, issue_pend, waiting, exp_tx_dv, exp_drop;
    logic [7:0]     exp_tx_byte;

    uart_line_buffer #(
      .DEPTH      (D),
      .MODE       (M),
      .FLUSH_EN   (1),
      .FLUSH_CHAR (8'h0D)
    ) dut (
      .hwclk     (hwclk),
      .rst_n     (rst_n),
      .rx_dv     (rx_dv[g]),
      .rx_byte   (rx_byte[g]),
      .tx_active (tx_active),
      .tx_done   (tx_done_in),
      .tx_dv     (tx_dv),
      .tx_byte   (tx_byte),
      .busy      (busy),
      .drop      (drop),
      .level     (level)
    );

    // uart_tx stand-in: busy for a few cycles after each start strobe
    always @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
        tx_cnt    <= 0;
        tx_done_m <= 1'b0;
      end else begin
        tx_done_m <= (tx_cnt == 1);
        if (tx_dv) tx_cnt <= 3 + g;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
      end
    end

    assign tx_active    = hold_active[g] | (tx_cnt != 0);
    assign tx_done_in   = tx_done_m | spur_done[g];
    assign tx_dv_o[g]   = tx_dv;
    assign busy_o[g]    = busy;
    assign drop_o[g]    = drop;
    assign tx_done_o[g] = tx_done_m;
    assign tx_byte_o[g] = tx_byte;
    assign level_o[g]   = 8'(level);
    assign model_busy[g] = draining;

    // Reference model: a byte list that turns into an echo list on trigger
    initial begin
      done_cnt[g] = 0;
      forever begin
        @(posedge hwclk or negedge rst_n);
        if (!rst_n) begin
          store.delete();
          pend.delete();
          draining    = 1'b0;
          issue_pend  = 1'b0;
          waiting     = 1'b0;
          exp_tx_dv   = 1'b0;
          exp_drop    = 1'b0;
          exp_tx_byte = 8'h00;
        end else begin
          automatic bit was_draining = draining;
          exp_tx_dv = 1'b0;
          exp_drop  = 1'b0;
          if (issue_pend) begin
            if (!tx_active) begin
              exp_tx_dv   = 1'b1;
              exp_tx_byte = pend[0];
              issue_pend  = 1'b0;
              waiting     = 1'b1;
            end
          end else if (waiting && tx_done_in) begin
            waiting = 1'b0;
            void'(pend.pop_front());
            done_cnt[g]++;
            if (pend.size() == 0) draining = 1'b0;
            else issue_pend = 1'b1;
          end
          if (rx_dv[g]) begin
            if (was_draining) begin
              exp_drop = 1'b1;
            end else begin
              store.push_back(rx_byte[g]);
              if ((store.size() == D) || (rx_byte[g] == 8'h0D)) begin
                pend.delete();
                if (M == MODE_FIFO) begin
                  foreach (store[i]) pend.push_back(store[i]);
                end else begin
                  for (int i = store.size() - 1; i >= 0; i--) pend.push_back(store[i]);
                end
                store.delete();
                draining   = 1'b1;
                issue_pend = 1'b1;
              end
            end
          end
        end
      end
    end

    initial begin
      forever begin
        @(negedge hwclk);
        if (rst_n) begin
          check_output("tx_dv", g, tx_dv, exp_tx_dv);
          if (exp_tx_dv) check_output("tx_byte", g, tx_byte, exp_tx_byte);
          check_output("drop", g, drop, exp_drop);
          check_output("busy", g, busy, draining);
          check_output("level", g, level, draining ? pend.size() : store.size());
          if (tx_dv) echo_q[g].push_back(tx_byte);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int base;
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    rx_dv       = '0;
    hold_active = '0;
    spur_done   = '0;
    for (int i = 0; i < NI; i++) rx_byte[i] = 8'h00;

    vecs[0] = '{0, 4, 64'h41424344_00000000, 64'h44434241_00000000};
    vecs[1] = '{1, 4, 64'h01020304_00000000, 64'h01020304_00000000};
    vecs[2] = '{2, 3, 64'h68690D00_00000000, 64'h0D696800_00000000};
    vecs[3] = '{1, 2, 64'h780D0000_00000000, 64'h780D0000_00000000};
    vecs[4] = '{0, 1, 64'h0D000000_00000000, 64'h0D000000_00000000};
    vecs[5] = '{2, 8, 64'h11223344_55667788, 64'h88776655_44332211};

    repeat (3) @(negedge hwclk);
    for (int i = 0; i < NI; i++) begin
      check_output("rst_tx_dv", i, tx_dv_o[i], 0);
      check_output("rst_tx_byte", i, tx_byte_o[i], 0);
      check_output("rst_busy", i, busy_o[i], 0);
      check_output("rst_drop", i, drop_o[i], 0);
      check_output("rst_level", i, level_o[i], 0);
    end
    #2 rst_n = 1'b1;

    $display("[TB] directed vectors");
    for (int v = 0; v < 6; v++) begin
      automatic int ii = vecs[v].inst;
      echo_q[ii].delete();
      for (int k = 0; k < vecs[v].n; k++) apply_stimulus(ii, get_byte(vecs[v].rx, k));
      wait_idle(ii);
      check_echo("vec_echo", ii, vecs[v].ex, vecs[v].n);
      check_output("vec_level", v, level_o[ii], 0);
    end

    $display("[TB] FIFO first-byte latency");
    echo_q[1].delete();
    for (int k = 0; k < 3; k++) apply_stimulus(1, 8'(8'h05 + k));
    @(negedge hwclk);
    rx_dv[1]   = 1'b1;
    rx_byte[1] = 8'h08;
    n = 0;
    do begin
      @(negedge hwclk);
      rx_dv[1] = 1'b0;
      n++;
    end while (!tx_dv_o[1] && n < 20);
    check_output("first_latency", 1, n, 2);
    wait_idle(1);
    check_echo("lat_echo", 1, 64'h05060708_00000000, 4);

    $display("[TB] drop during drain");
    echo_q[0].delete();
    for (int k = 0; k < 4; k++) apply_stimulus(0, 8'(8'h41 + k));
    n = 0;
    while (!tx_dv_o[0] && n < 20) begin @(negedge hwclk); n++; end
    check_output("drop_setup", 0, tx_dv_o[0], 1);
    rx_dv[0]   = 1'b1;
    rx_byte[0] = 8'h5A;
    @(negedge hwclk);
    rx_dv[0] = 1'b0;
    check_output("drop_pulse", 0, drop_o[0], 1);
    check_output("drop_level", 0, level_o[0], 4);
    @(negedge hwclk);
    check_output("drop_clear", 0, drop_o[0], 0);
    wait_idle(0);
    check_echo("drop_echo", 0, 64'h44434241_00000000, 4);

    $display("[TB] rx on final tx_done");
    echo_q[0].delete();
    for (int k = 0; k < 4; k++) apply_stimulus(0, 8'(8'h45 + k));
    n = 0;
    while (!(tx_done_o[0] && echo_q[0].size() == 4) && n < 200) begin @(negedge hwclk); n++; end
    check_output("final_setup", 0, tx_done_o[0], 1);
    rx_dv[0]   = 1'b1;
    rx_byte[0] = 8'h59;
    @(negedge hwclk);
    rx_dv[0] = 1'b0;
    check_output("final_drop", 0, drop_o[0], 1);
    check_output("final_busy", 0, busy_o[0], 0);
    check_output("final_level", 0, level_o[0], 0);
    check_echo("final_echo", 0, 64'h48474645_00000000, 4);

    $display("[TB] backpressure");
    echo_q[1].delete();
    hold_active[1] = 1'b1;
    for (int k = 0; k < 4; k++) apply_stimulus(1, 8'(8'hA0 + k));
    n = 0;
    repeat (50) begin
      @(negedge hwclk);
      if (tx_dv_o[1]) n++;
    end
    check_output("bp_no_tx", 1, n, 0);
    hold_active[1] = 1'b0;
    @(negedge hwclk);
    check_output("bp_release_tx", 1, tx_dv_o[1], 1);
    @(negedge hwclk);
    check_output("bp_one_cycle", 1, tx_dv_o[1], 0);
    wait_idle(1);
    check_echo("bp_echo", 1, 64'hA0A1A2A3_00000000, 4);

    $display("[TB] spurious tx_done in FILL");
    echo_q[2].delete();
    apply_stimulus(2, 8'h61);
    spur_done[2] = 1'b1;
    @(negedge hwclk);
    spur_done[2] = 1'b0;
    @(negedge hwclk);
    check_output("spur_level", 2, level_o[2], 1);
    check_output("spur_busy", 2, busy_o[2], 0);
    apply_stimulus(2, 8'h0D);
    wait_idle(2);
    check_echo("spur_echo", 2, 64'h0D610000_00000000, 2);

    $display("[TB] reset mid-drain");
    echo_q[0].delete();
    base = done_cnt[0];
    for (int k = 0; k < 4; k++) apply_stimulus(0, 8'(8'h41 + k));
    n = 0;
    while (!(done_cnt[0] == base + 2 && tx_dv_o[0]) && n < 200) begin @(negedge hwclk); n++; end
    check_output("rst_setup", 0, tx_dv_o[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_mid_tx_dv", 0, tx_dv_o[0], 0);
    check_output("rst_mid_busy", 0, busy_o[0], 0);
    check_output("rst_mid_level", 0, level_o[0], 0);
    repeat (3) @(negedge hwclk);
    #2 rst_n = 1'b1;
    echo_q[0].delete();
    apply_stimulus(0, 8'h51);
    repeat (10) @(negedge hwclk);
    check_output("post_rst_level", 0, level_o[0], 1);
    check_output("post_rst_busy", 0, busy_o[0], 0);
    check_output("post_rst_no_tx", 0, echo_q[0].size(), 0);

    $display("[TB] random traffic");
    for (int it = 0; it < 400; it++) begin
      automatic int ii = $urandom_range(0, NI - 1);
      automatic logic [7:0] b = ($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) hold_active[$urandom_range(0, NI - 1)] = 1'b1;
      if ($urandom_range(0, 3) == 0) hold_active = '0;
      apply_stimulus(ii, b);
      repeat ($urandom_range(0, 3)) @(negedge hwclk);
    end
    hold_active = '0;
    for (int i = 0; i < NI; i++) wait_idle(i);
    repeat (5) @(negedge hwclk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
